// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter and the fetch/hazard units.
package imem_pkg;

  typedef enum logic {ARB_BOOT, ARB_RUN} arb_state_t;

  localparam logic [31:0] NOP_INSTR         = 32'h00000013;
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'hBFC00000;

  // True when addr falls inside the window of 2**aw bytes that starts at base.
  function automatic logic in_window(input logic [31:0] addr, input logic [31:0] base,
                                     input int unsigned aw);
    return (addr >> aw) == (base >> aw);
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Loader, fetch and memory-port signals of the instruction-memory arbiter.
interface imem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 12
);
  logic                  ld_valid;
  logic                  ld_ready;
  logic [31:0]           ld_addr;
  logic [7:0]            ld_data;
  logic                  ld_last;
  logic                  f_req;
  logic [31:0]           f_addr;
  logic [31:0]           f_instr;
  logic                  f_stall;
  logic                  cpu_hold;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [7:0]            mem_wdata;
  logic [31:0]           mem_rdata;
  logic                  addr_err;
  logic [ADDR_WIDTH:0]   load_count;

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_last, f_req, f_addr, mem_rdata,
    output ld_ready, f_instr, f_stall, cpu_hold, mem_addr, mem_we, mem_wdata,
           addr_err, load_count
  );

  modport master (
    output ld_valid, ld_addr, ld_data, ld_last, f_req, f_addr, mem_rdata,
    input  ld_ready, f_instr, f_stall, cpu_hold, mem_addr, mem_we, mem_wdata,
           addr_err, load_count
  );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction memory between the fetch stage and the program loader:
// BOOT holds the CPU while the image loads, RUN favours fetch with a bounded loader wait.
module imem_arbiter
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic clk,
  input  logic rst,
  imem_arbiter_if.slave bus
);

  localparam int unsigned         WAIT_W   = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [ADDR_WIDTH:0] LOAD_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  arb_state_t          state_q, state_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic                addr_err_q, addr_err_d;
  logic [ADDR_WIDTH:0] load_count_q, load_count_d;
  logic                ld_accept;
  logic                ld_in_win;
  logic                f_in_win;

  assign ld_in_win      = in_window(bus.ld_addr, BASE_ADDR, ADDR_WIDTH);
  assign f_in_win       = in_window(bus.f_addr, BASE_ADDR, ADDR_WIDTH);
  assign bus.addr_err   = addr_err_q;
  assign bus.load_count = load_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_BOOT;
      wait_cnt_q   <= '0;
      addr_err_q   <= 1'b0;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_err_q   <= addr_err_d;
      load_count_q <= load_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    addr_err_d    = addr_err_q;
    load_count_d  = load_count_q;
    ld_accept     = 1'b0;
    bus.ld_ready  = 1'b0;
    bus.f_stall   = 1'b0;
    bus.f_instr   = NOP_INSTR;
    bus.cpu_hold  = 1'b0;
    bus.mem_addr  = bus.f_addr[ADDR_WIDTH-1:0];
    bus.mem_we    = 1'b0;
    bus.mem_wdata = bus.ld_data;

    case (state_q)
      ARB_BOOT: begin
        // Keep the memory port quiet while reset is still asserted.
        bus.cpu_hold = 1'b1;
        bus.f_stall  = 1'b1;
        bus.ld_ready = !rst;
        ld_accept    = bus.ld_valid && !rst;
        wait_cnt_d   = '0;
        if (ld_accept && bus.ld_last) state_d = ARB_RUN;
      end
      ARB_RUN: begin
        bus.ld_ready = !bus.f_req || (wait_cnt_q == WAIT_MAX);
        ld_accept    = bus.ld_valid && bus.ld_ready;
        if (bus.f_req && ld_accept) begin
          bus.f_stall = 1'b1;
        end else if (bus.f_req) begin
          if (f_in_win) bus.f_instr = bus.mem_rdata;
          else          addr_err_d  = 1'b1;
        end
        if (!bus.ld_valid || ld_accept) wait_cnt_d = '0;
        else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      end
    endcase

    // Out-of-window beats are consumed but never written.
    if (ld_accept) begin
      bus.mem_addr = bus.ld_addr[ADDR_WIDTH-1:0];
      if (ld_in_win) begin
        bus.mem_we = 1'b1;
        if (load_count_q != LOAD_MAX) load_count_d = load_count_q + (ADDR_WIDTH+1)'(1);
      end else begin
        addr_err_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: vector tables through a scoreboard queue, plus reset sequences.
module tb_imem_arbiter;
  localparam int unsigned AW = 12;
  localparam logic [31:0] NOP = 32'h00000013;

  typedef struct {
    logic        ld_valid;
    logic [31:0] ld_addr;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        f_req;
    logic [31:0] f_addr;
    logic        e_ld_ready;
    logic        e_f_stall;
    logic [31:0] e_f_instr;
    logic        e_cpu_hold;
    logic        e_mem_we;
    logic        e_addr_err;
    logic [AW:0] e_load_count;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] mem_m [0:(1<<AW)-1];
  vec_t exp_q [$];
  vec_t vecs [$];

  imem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  imem_arbiter #(.ADDR_WIDTH(AW), .BASE_ADDR(32'hBFC00000), .MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // External byte memory: 4-byte big-endian read, wrapping at the window end.
  always_comb begin
    logic [AW-1:0] a;
    a = bus.mem_addr;
    bus.mem_rdata = {mem_m[a], mem_m[a + AW'(1)], mem_m[a + AW'(2)], mem_m[a + AW'(3)]};
  end

  always @(posedge clk) if (bus.mem_we) mem_m[bus.mem_addr] <= bus.mem_wdata;

  function automatic vec_t mk(input logic lv, input logic [31:0] la, input logic [7:0] ldat,
                              input logic ll, input logic fr, input logic [31:0] fa,
                              input logic er, input logic es, input logic [31:0] ei,
                              input logic eh, input logic ew, input logic ee,
                              input logic [AW:0] ec);
    vec_t v;
    v.ld_valid = lv; v.ld_addr = la; v.ld_data = ldat; v.ld_last = ll;
    v.f_req = fr; v.f_addr = fa;
    v.e_ld_ready = er; v.e_f_stall = es; v.e_f_instr = ei; v.e_cpu_hold = eh;
    v.e_mem_we = ew; v.e_addr_err = ee; v.e_load_count = ec;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".cpu_hold"},   32'(bus.cpu_hold),   32'd1);
    chk({tag, ".f_stall"},    32'(bus.f_stall),    32'd1);
    chk({tag, ".f_instr"},    bus.f_instr,         NOP);
    chk({tag, ".mem_we"},     32'(bus.mem_we),     32'd0);
    chk({tag, ".load_count"}, 32'(bus.load_count), 32'd0);
    chk({tag, ".addr_err"},   32'(bus.addr_err),   32'd0);
  endtask

  task automatic idle_inputs();
    bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0; bus.ld_last = 1'b0;
    bus.f_req = 1'b0; bus.f_addr = '0;
  endtask

  // Drive one vector, queue its expectation, compare at the falling edge, advance a cycle.
  task automatic apply(input int id, input vec_t v);
    vec_t e;
    string t;
    bus.ld_valid = v.ld_valid; bus.ld_addr = v.ld_addr; bus.ld_data = v.ld_data;
    bus.ld_last = v.ld_last; bus.f_req = v.f_req; bus.f_addr = v.f_addr;
    exp_q.push_back(v);
    @(negedge clk);
    e = exp_q.pop_front();
    t = $sformatf("v%0d", id);
    chk({t, ".ld_ready"},   32'(bus.ld_ready),   32'(e.e_ld_ready));
    chk({t, ".f_stall"},    32'(bus.f_stall),    32'(e.e_f_stall));
    chk({t, ".f_instr"},    bus.f_instr,         e.e_f_instr);
    chk({t, ".cpu_hold"},   32'(bus.cpu_hold),   32'(e.e_cpu_hold));
    chk({t, ".mem_we"},     32'(bus.mem_we),     32'(e.e_mem_we));
    chk({t, ".addr_err"},   32'(bus.addr_err),   32'(e.e_addr_err));
    chk({t, ".load_count"}, 32'(bus.load_count), 32'(e.e_load_count));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] img [0:7];
    for (int i = 0; i < (1 << AW); i++) mem_m[i] = 8'h00;
    img[0] = 8'h00; img[1] = 8'hA0; img[2] = 8'h00; img[3] = 8'h93;
    img[4] = 8'h00; img[5] = 8'h10; img[6] = 8'h01; img[7] = 8'h13;

    // Phase 1: boot image, starvation bound, patch, out-of-window traffic.
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1, 32'hBFC00000 + 32'(i), img[i], i == 7, 1, 32'hBFC00004,
                        1, 1, NOP, 1, 1, 0, (AW+1)'(i)));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'hBFC00004, 0, 0, 32'h00100113, 0, 0, 0, 8));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(1, 32'hBFC00010, 8'h55, 0, 1, 32'hBFC00000, 0, 0, 32'h00A00093, 0, 0, 0, 8));
    vecs.push_back(mk(1, 32'hBFC00010, 8'h55, 0, 1, 32'hBFC00000, 1, 1, NOP, 0, 1, 0, 8));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'hBFC00000, 0, 0, 32'h00A00093, 0, 0, 0, 9));
    vecs.push_back(mk(1, 32'hBFC00007, 8'h00, 1, 0, 0, 1, 0, NOP, 0, 1, 0, 9));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'hBFC00004, 0, 0, 32'h00100100, 0, 0, 0, 10));
    vecs.push_back(mk(1, 32'h80000000, 8'hAA, 0, 0, 0, 1, 0, NOP, 0, 0, 0, 10));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h00000000, 0, 0, NOP, 0, 0, 1, 10));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, NOP, 0, 0, 1, 10));

    idle_inputs();
    #2;
    chk_reset("por");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

    // Asynchronous reset in the middle of a cycle with a beat pending.
    bus.ld_valid = 1'b1; bus.ld_addr = 32'hBFC00020; bus.ld_data = 8'h77;
    #2;
    rst = 1'b1;
    #1;
    chk_reset("rst_async");
    @(negedge clk);
    chk_reset("rst_held");
    idle_inputs();
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Phase 2: load both ends of the window, wrapped fetch, fetch-side window error.
    vecs.delete();
    vecs.push_back(mk(1, 32'hBFC00FFE, 8'h11, 0, 1, 32'h00000000, 1, 1, NOP, 1, 1, 0, 0));
    vecs.push_back(mk(1, 32'hBFC00FFF, 8'h22, 0, 1, 32'h00000000, 1, 1, NOP, 1, 1, 0, 1));
    vecs.push_back(mk(1, 32'hBFC00000, 8'h33, 0, 1, 32'h00000000, 1, 1, NOP, 1, 1, 0, 2));
    vecs.push_back(mk(1, 32'hBFC00001, 8'h44, 1, 1, 32'h00000000, 1, 1, NOP, 1, 1, 0, 3));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'hBFC00FFE, 0, 0, 32'h11223344, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 1, 32'h00000000, 0, 0, NOP, 0, 0, 0, 4));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, NOP, 0, 0, 1, 4));
    for (int i = 0; i < vecs.size(); i++) apply(100 + i, vecs[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
